uart_command_decoder: RTL and testbench

- Sits between the UART receiver/transmitter and the PSRAM/framebuffer access port of top_testpic_generator; directly upstream of the memory path.
- Parses host byte commands: "W" addr_hi addr_lo data (write) and "R" addr_hi addr_lo (read).
- Issues single memory requests over a req/ack handshake.
- Returns each read byte to the UART transmitter.

---
 rtl/uart_cmd_pkg.sv | 30 +++
 rtl/byte_timeout.sv | 30 +++
 rtl/uart_command_decoder.sv | 165 ++++++++++++++++
 tb/tb_uart_command_decoder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types for the UART command decoder: FSM states, opcode defaults and
// the memory request record.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_DATA    = 3'd3,
    ST_ISSUE   = 3'd4,
    ST_WAIT_RD = 3'd5,
    ST_TX_RESP = 3'd6
  } cmd_state_e;

  localparam logic [7:0] CMD_WRITE_DEF = 8'h57;  // "W"
  localparam logic [7:0] CMD_READ_DEF  = 8'h52;  // "R"

  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } mem_req_t;

  function automatic logic is_opcode(input logic [7:0] b,
                                     input logic [7:0] op_w,
                                     input logic [7:0] op_r);
    return (b == op_w) || (b == op_r);
  endfunction

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte watchdog: counts enabled idle cycles and flags the cycle in which
// the count reaches CYCLES-1. Any clear or a disabled cycle restarts it.
module byte_timeout #(
  parameter int CYCLES = 2700000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear || !enable) begin
      count_q <= '0;
    end else if (count_q != LAST) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expired = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/uart_command_decoder.sv
// Parses "W" hi lo data / "R" hi lo byte commands from the UART, issues one
// memory request per command and sends each read byte back to the transmitter.
module uart_command_decoder
  import uart_cmd_pkg::*;
#(
  parameter int         ADDR_W         = 16,
  parameter int         TIMEOUT_CYCLES = 2700000,
  parameter logic [7:0] CMD_WRITE      = CMD_WRITE_DEF,
  parameter logic [7:0] CMD_READ       = CMD_READ_DEF
) (
  input  logic              clk,
  input  logic              sys_resetn,
  input  logic [7:0]        i_com_data,
  input  logic              i_com_strobe,
  output logic              o_mem_req,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic              i_mem_rvalid,
  input  logic [7:0]        i_mem_rdata,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_strobe,
  input  logic              i_tx_busy,
  output logic              o_busy,
  output logic              o_error,
  output cmd_state_e        dbg_state
);

  // Memory handshake: o_mem_req is a registered valid that stays high with
  // write/addr/wdata frozen until a cycle with o_mem_req && i_mem_ack; that
  // cycle is the transfer and req drops on the next edge. ack with req low is
  // a no-op. Read data returns later as a one-cycle i_mem_rvalid pulse.
  cmd_state_e state_q, state_d;
  logic       req_q, req_d;
  logic       error_q, error_d;
  mem_req_t   mem_req_q;
  logic [7:0] tx_data_q;

  logic lat_op, lat_hi, lat_lo, lat_data, lat_rd;
  logic to_enable, to_expired;

  assign to_enable = (state_q == ST_ADDR_HI) || (state_q == ST_ADDR_LO) ||
                     (state_q == ST_DATA);

  byte_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_byte_timeout (
    .clk     (clk),
    .rst_n   (sys_resetn),
    .clear   (i_com_strobe),
    .enable  (to_enable),
    .expired (to_expired)
  );

  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    error_d  = 1'b0;
    lat_op   = 1'b0;
    lat_hi   = 1'b0;
    lat_lo   = 1'b0;
    lat_data = 1'b0;
    lat_rd   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_com_strobe && is_opcode(i_com_data, CMD_WRITE, CMD_READ)) begin
          lat_op  = 1'b1;
          state_d = ST_ADDR_HI;
        end
      end
      ST_ADDR_HI: begin
        if (i_com_strobe) begin
          lat_hi  = 1'b1;
          state_d = ST_ADDR_LO;
        end else if (to_expired) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ADDR_LO: begin
        if (i_com_strobe) begin
          lat_lo  = 1'b1;
          state_d = mem_req_q.write ? ST_DATA : ST_ISSUE;
        end else if (to_expired) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (i_com_strobe) begin
          lat_data = 1'b1;
          state_d  = ST_ISSUE;
        end else if (to_expired) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        error_d = i_com_strobe;
        if (!req_q) begin
          req_d = 1'b1;
        end else if (i_mem_ack) begin
          req_d   = 1'b0;
          state_d = mem_req_q.write ? ST_IDLE : ST_WAIT_RD;
        end
      end
      ST_WAIT_RD: begin
        error_d = i_com_strobe;
        if (i_mem_rvalid) begin
          lat_rd  = 1'b1;
          state_d = ST_TX_RESP;
        end
      end
      ST_TX_RESP: begin
        error_d = i_com_strobe;
        if (!i_tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      mem_req_q <= '0;
      tx_data_q <= '0;
    end else begin
      if (lat_op)   mem_req_q.write      <= (i_com_data == CMD_WRITE);
      if (lat_hi)   mem_req_q.addr[15:8] <= i_com_data;
      if (lat_lo)   mem_req_q.addr[7:0]  <= i_com_data;
      if (lat_data) mem_req_q.wdata      <= i_com_data;
      if (lat_rd)   tx_data_q            <= i_mem_rdata;
    end
  end

  // The send pulse follows the transmitter directly so a free transmitter
  // gets the byte in the cycle right after rvalid.
  assign o_tx_strobe = (state_q == ST_TX_RESP) && !i_tx_busy;
  assign o_tx_data   = tx_data_q;
  assign o_mem_req   = req_q;
  assign o_mem_write = mem_req_q.write;
  assign o_mem_addr  = mem_req_q.addr;
  assign o_mem_wdata = mem_req_q.wdata;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_error     = error_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_command_decoder.sv
// Directed bench for uart_command_decoder: write, read, backpressure, timeout,
// dropped bytes and reset during a pending read.
module tb_uart_command_decoder;
  import uart_cmd_pkg::*;

  localparam int TO = 50;

  // clock / reset
  logic clk = 1'b0;
  logic sys_resetn = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  i_com_data;
  logic        i_com_strobe;
  logic        o_mem_req;
  logic        o_mem_write;
  logic [15:0] o_mem_addr;
  logic [7:0]  o_mem_wdata;
  logic        i_mem_ack;
  logic        i_mem_rvalid;
  logic [7:0]  i_mem_rdata;
  logic [7:0]  o_tx_data;
  logic        o_tx_strobe;
  logic        i_tx_busy;
  logic        o_busy;
  logic        o_error;
  cmd_state_e  dbg_state;

  uart_command_decoder #(
    .ADDR_W         (16),
    .TIMEOUT_CYCLES (TO),
    .CMD_WRITE      (CMD_WRITE_DEF),
    .CMD_READ       (CMD_READ_DEF)
  ) dut (
    .clk          (clk),
    .sys_resetn   (sys_resetn),
    .i_com_data   (i_com_data),
    .i_com_strobe (i_com_strobe),
    .o_mem_req    (o_mem_req),
    .o_mem_write  (o_mem_write),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_ack    (i_mem_ack),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_tx_data    (o_tx_data),
    .o_tx_strobe  (o_tx_strobe),
    .i_tx_busy    (i_tx_busy),
    .o_busy       (o_busy),
    .o_error      (o_error),
    .dbg_state    (dbg_state)
  );

  // scoreboard state
  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0] exp_q[$];

  int          n_acc = 0;
  int          n_tx = 0;
  int          n_errp = 0;
  logic        acc_write = 1'b0;
  logic [15:0] acc_addr = '0;
  logic [7:0]  acc_wdata = '0;
  logic [7:0]  tx_last = '0;

  always @(posedge clk) begin
    if (o_mem_req && i_mem_ack) begin
      n_acc++;
      acc_write = o_mem_write;
      acc_addr  = o_mem_addr;
      acc_wdata = o_mem_wdata;
    end
    if (o_tx_strobe) begin
      n_tx++;
      tx_last = o_tx_data;
    end
    if (o_error) n_errp++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks, all entered and left on a falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_com_data   = b;
    i_com_strobe = 1'b1;
    @(negedge clk);
    i_com_strobe = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (!o_mem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(o_mem_req), 1);
  endtask

  task automatic do_ack;
    i_mem_ack = 1'b1;
    @(negedge clk);
    i_mem_ack = 1'b0;
  endtask

  task automatic pulse_rvalid(input logic [7:0] d);
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = d;
    @(negedge clk);
    i_mem_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  int a0, t0, e0, bad;

  initial begin
    i_com_data = '0; i_com_strobe = 1'b0; i_mem_ack = 1'b0;
    i_mem_rvalid = 1'b0; i_mem_rdata = '0; i_tx_busy = 1'b0;

    // reset values
    tick(2);
    check("rst_req", 32'(o_mem_req), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_error", 32'(o_error), 0);
    check("rst_tx_strobe", 32'(o_tx_strobe), 0);
    check("rst_addr", 32'(o_mem_addr), 0);
    check("rst_tx_data", 32'(o_tx_data), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    sys_resetn = 1'b1;
    tick(2);

    // write "W" 00 04 42
    a0 = n_acc; t0 = n_tx;
    send_byte(CMD_WRITE_DEF); send_byte(8'h00); send_byte(8'h04); send_byte(8'd42);
    check("wr_req_cycle1", 32'(o_mem_req), 0);
    tick(1);
    check("wr_req_cycle2", 32'(o_mem_req), 1);
    tick(1);
    do_ack;
    check("wr_req_drop", 32'(o_mem_req), 0);
    check("wr_idle", 32'(o_busy), 0);
    check("wr_acc_count", 32'(n_acc - a0), 1);
    check("wr_write", 32'(acc_write), 1);
    check("wr_addr", 32'(acc_addr), 32'h0004);
    check("wr_wdata", 32'(acc_wdata), 32'h2A);
    check("wr_no_tx", 32'(n_tx - t0), 0);

    // read "R" 00 04, data back 5 cycles after ack
    a0 = n_acc; t0 = n_tx;
    send_byte(CMD_READ_DEF); send_byte(8'h00); send_byte(8'h04);
    wait_req("rd_req");
    check("rd_write", 32'(o_mem_write), 0);
    check("rd_addr", 32'(o_mem_addr), 32'h0004);
    do_ack;
    check("rd_wait_state", 32'(dbg_state), 32'(ST_WAIT_RD));
    tick(4);
    exp_q.push_back(8'h2A);
    pulse_rvalid(8'h2A);
    check("rd_tx_latency", 32'(o_tx_strobe), 1);
    tick(1);
    check("rd_tx_count", 32'(n_tx - t0), 1);
    check("rd_tx_data", 32'(tx_last), 32'(exp_q.pop_front()));
    check("rd_acc_count", 32'(n_acc - a0), 1);
    check("rd_idle", 32'(o_busy), 0);

    // backpressure: ack held off, then transmitter busy
    a0 = n_acc; t0 = n_tx;
    send_byte(CMD_READ_DEF); send_byte(8'h12); send_byte(8'h34);
    wait_req("bp_req");
    bad = 0;
    repeat (10) begin
      if (o_mem_req !== 1'b1 || o_mem_addr !== 16'h1234 || o_mem_write !== 1'b0) bad++;
      tick(1);
    end
    check("bp_req_stable", 32'(bad), 0);
    do_ack;
    check("bp_acc_count", 32'(n_acc - a0), 1);
    i_tx_busy = 1'b1;
    tick(2);
    exp_q.push_back(8'h5A);
    pulse_rvalid(8'h5A);
    bad = 0;
    repeat (20) begin
      if (o_tx_strobe !== 1'b0) bad++;
      tick(1);
    end
    check("bp_no_strobe_busy", 32'(bad), 0);
    check("bp_tx_state", 32'(dbg_state), 32'(ST_TX_RESP));
    i_tx_busy = 1'b0;
    #1;
    check("bp_strobe_on_release", 32'(o_tx_strobe), 1);
    tick(1);
    tick(3);
    check("bp_tx_count", 32'(n_tx - t0), 1);
    check("bp_tx_data", 32'(tx_last), 32'(exp_q.pop_front()));

    // timeout after "W" 00
    a0 = n_acc; e0 = n_errp;
    send_byte(CMD_WRITE_DEF); send_byte(8'h00);
    bad = 0;
    repeat (TO - 1) begin
      tick(1);
      if (o_error !== 1'b0 || o_busy !== 1'b1) bad++;
    end
    check("to_no_early_abort", 32'(bad), 0);
    tick(1);
    check("to_error_pulse", 32'(o_error), 1);
    check("to_idle", 32'(o_busy), 0);
    tick(1);
    check("to_error_one_cycle", 32'(o_error), 0);
    check("to_error_count", 32'(n_errp - e0), 1);
    check("to_no_req", 32'(n_acc - a0), 0);
    t0 = n_tx;
    send_byte(CMD_READ_DEF); send_byte(8'h00); send_byte(8'h01);
    wait_req("to_next_req");
    check("to_next_addr", 32'(o_mem_addr), 32'h0001);
    do_ack;
    tick(1);
    exp_q.push_back(8'h77);
    pulse_rvalid(8'h77);
    tick(1);
    check("to_next_tx_count", 32'(n_tx - t0), 1);
    check("to_next_tx_data", 32'(tx_last), 32'(exp_q.pop_front()));

    // garbage in IDLE, stray ack/rvalid, byte dropped during WAIT_RD
    a0 = n_acc; e0 = n_errp; t0 = n_tx;
    send_byte(8'h00); send_byte(8'hFF);
    do_ack;
    pulse_rvalid(8'h11);
    tick(1);
    check("gb_idle", 32'(o_busy), 0);
    check("gb_no_error", 32'(n_errp - e0), 0);
    check("gb_no_req", 32'(n_acc - a0), 0);
    check("gb_no_tx", 32'(n_tx - t0), 0);
    send_byte(CMD_READ_DEF); send_byte(8'h00); send_byte(8'h02);
    wait_req("dr_req");
    do_ack;
    send_byte(CMD_WRITE_DEF);
    check("dr_error_pulse", 32'(o_error), 1);
    check("dr_still_wait", 32'(dbg_state), 32'(ST_WAIT_RD));
    tick(1);
    check("dr_error_count", 32'(n_errp - e0), 1);
    exp_q.push_back(8'h99);
    pulse_rvalid(8'h99);
    tick(1);
    check("dr_tx_count", 32'(n_tx - t0), 1);
    check("dr_tx_data", 32'(tx_last), 32'(exp_q.pop_front()));

    // reset while a read is pending
    t0 = n_tx;
    send_byte(CMD_READ_DEF); send_byte(8'h00); send_byte(8'h03);
    wait_req("rm_req");
    do_ack;
    check("rm_wait_state", 32'(dbg_state), 32'(ST_WAIT_RD));
    sys_resetn = 1'b0;
    #1;
    check("rm_req", 32'(o_mem_req), 0);
    check("rm_busy", 32'(o_busy), 0);
    check("rm_addr", 32'(o_mem_addr), 0);
    check("rm_tx_data", 32'(o_tx_data), 0);
    check("rm_error", 32'(o_error), 0);
    @(negedge clk);
    sys_resetn = 1'b1;
    tick(1);
    pulse_rvalid(8'hEE);
    tick(3);
    check("rm_no_tx", 32'(n_tx - t0), 0);
    check("rm_idle", 32'(o_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
